hslp_err_acc: RTL and testbench

Streaming error-statistics stage that sits directly downstream of the 8x8 approximate multipliers. It consumes operand pairs together with the approximate product each multiplier produces. For every accepted sample it forms the exact product internally and the absolute error distance against the approximate product. Over a run of 2^N_LOG2 samples it accumulates sum of error distances, maximum error distance and erroneous-sample count, for on-FPGA accuracy characterisation of the multiplier variants.

---
 rtl/hslp_err_acc.sv | 65 ++++++
 tb/tb_hslp_err_acc.sv | 134 +++++++++++++
 2 files changed

// File: rtl/hslp_err_acc.sv
// hslp_err_acc: streaming error-distance statistics for 8x8 approximate multipliers
module hslp_err_acc #(
  parameter int N_LOG2 = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          a,
  input  logic [7:0]          b,
  input  logic [15:0]         prod8,
  output logic                busy,
  output logic                done,
  output logic [15+N_LOG2:0]  sum_ed,
  output logic [15:0]         max_ed,
  output logic [N_LOG2:0]     err_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [N_LOG2:0] last_idx = {1'b0, {N_LOG2{1'b1}}};
  state_t state, state_nx;
  logic [N_LOG2:0] acc_cnt;
  logic drain_cnt, acc, last, clr;
  logic s1_v, s2_v;
  logic [15:0] s1_exact, s1_p, s2_ed;
  // next-state and handshake/status decode
  always_comb begin
    in_ready = state == RUN;
    busy = state == RUN || state == DRAIN;
    done = state == DONE;
    acc = in_ready & in_valid;
    last = acc && acc_cnt == last_idx;
    clr = start && (state == IDLE || state == DONE);
    state_nx = clr ? RUN : last ? DRAIN : (state == DRAIN && drain_cnt) ? DONE : state;
  end
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // accept counter and two-cycle drain timer
  always_ff @(posedge clk) begin
    if (rst || clr) acc_cnt <= '0;
    else if (acc) acc_cnt <= acc_cnt + 1'b1;
    drain_cnt <= !rst && state == DRAIN && !drain_cnt;
  end
  // S1/S2: exact product, then absolute error in either direction
  always_ff @(posedge clk) begin
    s1_v <= !rst && acc;
    s2_v <= !rst && s1_v;
    s1_exact <= 16'(a) * 16'(b);
    s1_p <= prod8;
    s2_ed <= s1_exact >= s1_p ? s1_exact - s1_p : s1_p - s1_exact;
  end
  // S3: statistics accumulation, cleared by reset or a new run
  always_ff @(posedge clk)
    if (rst || clr) begin
      sum_ed <= '0;
      max_ed <= '0;
      err_cnt <= '0;
    end else if (s2_v) begin
      sum_ed <= sum_ed + {{N_LOG2{1'b0}}, s2_ed};
      max_ed <= s2_ed > max_ed ? s2_ed : max_ed;
      err_cnt <= err_cnt + {{N_LOG2{1'b0}}, |s2_ed};
    end
endmodule

// File: tb/tb_hslp_err_acc.sv
// tb_hslp_err_acc: directed-vector bench for hslp_err_acc with N_LOG2=2
module tb_hslp_err_acc;
  logic clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [7:0] a = 0, b = 0;
  logic [15:0] prod8 = 0;
  logic in_ready, busy, done;
  logic [17:0] sum_ed;
  logic [15:0] max_ed;
  logic [2:0] err_cnt;
  int nvec = 0, nmis = 0;

  hslp_err_acc #(.N_LOG2(2)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .prod8(prod8), .busy(busy), .done(done),
    .sum_ed(sum_ed), .max_ed(max_ed), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic [7:0] x, input logic [7:0] y, input logic [15:0] p);
    in_valid = 1; a = x; b = y; prod8 = p;
    step;
    in_valid = 0;
  endtask

  task automatic do_start;
    start = 1;
    step;
    start = 0;
  endtask

  task automatic wait_done;
    for (int k = 0; k < 20 && !done; k++) step;
    chk("done_seen", done, 1);
  endtask

  task automatic chk_stats(input string tag, input logic [63:0] s, input logic [63:0] m, input logic [63:0] c);
    chk({tag, "_sum"}, sum_ed, s);
    chk({tag, "_max"}, max_ed, m);
    chk({tag, "_cnt"}, err_cnt, c);
  endtask

  initial begin
    step; step;
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk_stats("rst", 0, 0, 0);
    rst = 0;
    step;
    do_start;
    chk("start_ready", in_ready, 1);
    chk("start_busy", busy, 1);
    smp(15, 15, 225);
    smp(255, 255, 65000);
    smp(16, 16, 300);
    smp(0, 0, 0);
    chk("last_ready", in_ready, 0);
    chk("last_busy", busy, 1);
    chk("last_done", done, 0);
    chk_stats("mid", 25, 25, 1);
    step;
    chk("l1_done", done, 0);
    chk("l1_busy", busy, 1);
    step;
    chk("l2_done", done, 1);
    chk("l2_busy", busy, 0);
    chk_stats("b2b", 69, 44, 2);
    step; step;
    chk_stats("hold", 69, 44, 2);
    do_start;
    chk("restart_done", done, 0);
    chk_stats("restart_clr", 0, 0, 0);
    smp(15, 15, 225);
    step;
    chk("bubble_busy", busy, 1);
    smp(255, 255, 65000);
    step;
    chk("bubble_ready", in_ready, 1);
    smp(16, 16, 300);
    step;
    smp(0, 0, 0);
    wait_done;
    chk_stats("gaps", 69, 44, 2);
    do_start;
    for (int i = 0; i < 4; i++) smp(255, 255, 0);
    wait_done;
    chk_stats("full", 260100, 65025, 4);
    do_start;
    chk_stats("clr_full", 0, 0, 0);
    for (int i = 0; i < 4; i++) smp(7, 9, 63);
    wait_done;
    chk_stats("exact", 0, 0, 0);
    do_start;
    smp(0, 0, 5);
    start = 1;
    smp(7, 9, 63);
    start = 0;
    smp(7, 9, 63);
    smp(7, 9, 63);
    chk("ign_ready", in_ready, 0);
    wait_done;
    chk_stats("ign_start", 5, 5, 1);
    do_start;
    smp(255, 255, 0);
    rst = 1;
    step;
    rst = 0;
    chk("mrst_ready", in_ready, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk_stats("mrst", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk_stats("post_rst", 0, 0, 0);
      chk("post_rst_busy", busy, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
